// File: rtl/can_pkg.sv
// Shared types and constants for the CAN frame sequencer.
package can_pkg;

  // Field states; SOF is kept as an encoding but the SOF bit is consumed in IDLE/IFS.
  typedef enum logic [4:0] {
    S_IDLE     = 5'd0,
    S_SOF      = 5'd1,
    S_ID_A     = 5'd2,
    S_RTR_A    = 5'd3,
    S_IDE      = 5'd4,
    S_ID_B     = 5'd5,
    S_RTR_B    = 5'd6,
    S_R1       = 5'd7,
    S_R0       = 5'd8,
    S_DLC      = 5'd9,
    S_DATA     = 5'd10,
    S_CRC      = 5'd11,
    S_CRC_DEL  = 5'd12,
    S_ACK_SLOT = 5'd13,
    S_ACK_DEL  = 5'd14,
    S_EOF      = 5'd15,
    S_IFS      = 5'd16,
    S_ERROR    = 5'd17
  } state_t;

  localparam int ID_A_LEN = 11;
  localparam int ID_B_LEN = 18;
  localparam int DLC_LEN  = 4;
  localparam int CRC_LEN  = 15;
  localparam int EOF_LEN  = 7;
  localparam int IFS_LEN  = 3;

  // Number of data-field bits for a DLC value, with DLC clipped to max_bytes.
  function automatic logic [6:0] data_bits(input logic [3:0] dlc_val, input int max_bytes);
    int n;
    n = (int'(dlc_val) > max_bytes) ? max_bytes : int'(dlc_val);
    return 7'(n * 8);
  endfunction

endpackage

// File: rtl/can_run_tracker.sv
// Tracks the run of equal bus bits and classifies the next bit as data, stuff or stuff error.
module can_run_tracker #(
  parameter int STUFF_LEN = 5
) (
  input  logic i_clock,
  input  logic i_reset,
  input  logic i_sp,
  input  logic i_bit,
  input  logic i_en,
  input  logic i_init,
  output logic o_is_stuff,
  output logic o_stuff_err,
  output logic o_will_pend
);
  localparam int RW = $clog2(STUFF_LEN + 1);

  logic          r_last;
  logic [RW-1:0] r_run;
  logic          r_pending;

  logic          w_same;
  logic [RW-1:0] w_run_inc;

  assign w_same    = (i_bit == r_last);
  assign w_run_inc = w_same ? (r_run + RW'(1)) : RW'(1);

  // A pending stuff bit must differ from the run; an equal bit is a stuff violation.
  assign o_is_stuff  = i_en && r_pending && !w_same;
  assign o_stuff_err = i_en && r_pending && w_same;
  // This bit, if accepted, completes a run and makes the next bit a stuff bit.
  assign o_will_pend = i_en && !r_pending && (w_run_inc == RW'(STUFF_LEN));

  // Run state update on each sample point; SOF reloads the run with one dominant bit.
  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      r_last    <= 1'b0;
      r_run     <= '0;
      r_pending <= 1'b0;
    end else if (i_sp) begin
      if (i_init) begin
        r_last    <= 1'b0;
        r_run     <= RW'(1);
        r_pending <= 1'b0;
      end else if (i_en) begin
        if (r_pending) begin
          if (!w_same) begin
            r_last    <= i_bit;
            r_run     <= RW'(1);
            r_pending <= 1'b0;
          end
        end else begin
          r_last    <= i_bit;
          r_run     <= w_run_inc;
          r_pending <= (w_run_inc == RW'(STUFF_LEN));
        end
      end
    end
  end

endmodule

// File: rtl/can_frame_sequencer.sv
// CAN 2.0A/B bit-level frame field sequencer with stuffing-window control.
module can_frame_sequencer
  import can_pkg::*;
#(
  parameter int STUFF_LEN      = 5,
  parameter int MAX_DATA_BYTES = 8,
  parameter int IDLE_BITS      = 11
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        sp,
  input  logic        rx_bit,
  output logic        f_stf,
  output logic        bit_valid,
  output logic        stuff_bit,
  output logic        stuff_error,
  output logic        form_error,
  output logic        frame_done,
  output logic [4:0]  state,
  output logic [28:0] id,
  output logic        ide,
  output logic        rtr,
  output logic [3:0]  dlc,
  output logic        ack_ok
);
  localparam int EW = $clog2(IDLE_BITS + 1);
  localparam logic [5:0] ID_A_LAST = 6'(ID_A_LEN - 1);
  localparam logic [5:0] ID_B_LAST = 6'(ID_B_LEN - 1);
  localparam logic [5:0] DLC_LAST  = 6'(DLC_LEN - 1);
  localparam logic [5:0] CRC_LAST  = 6'(CRC_LEN - 1);
  localparam logic [5:0] EOF_LAST  = 6'(EOF_LEN - 1);
  localparam logic [5:0] IFS_LAST  = 6'(IFS_LEN - 1);

  state_t        r_state;
  logic [5:0]    r_cnt;
  logic [EW-1:0] r_err_cnt;
  logic          r_crc_tail;
  logic          r_f_stf;
  logic          r_bit_valid, r_stuff_bit, r_stuff_error, r_form_error, r_frame_done;
  logic [28:0]   r_id;
  logic          r_ide, r_rtr, r_ack_ok;
  logic [3:0]    r_dlc;

  logic          w_win, w_sof, w_is_stuff, w_stuff_err, w_will_pend;
  logic [3:0]    w_dlc_shift;
  logic [6:0]    w_data_bits, w_dlc_bits;

  // Stuffing window covers every field from the first ID bit through the CRC (and its trailing stuff bit).
  always_comb begin
    w_win = 1'b0;
    case (r_state)
      S_ID_A, S_RTR_A, S_IDE, S_ID_B, S_RTR_B, S_R1, S_R0, S_DLC, S_DATA, S_CRC: w_win = 1'b1;
      default: w_win = 1'b0;
    endcase
  end

  assign w_sof       = sp && !rx_bit && ((r_state == S_IDLE) || ((r_state == S_IFS) && (r_cnt == IFS_LAST)));
  assign w_dlc_shift = {r_dlc[2:0], rx_bit};
  assign w_data_bits = data_bits(r_dlc, MAX_DATA_BYTES);
  assign w_dlc_bits  = data_bits(w_dlc_shift, MAX_DATA_BYTES);

  can_run_tracker #(.STUFF_LEN(STUFF_LEN)) u_run (
    .i_clock     (clock),
    .i_reset     (reset),
    .i_sp        (sp),
    .i_bit       (rx_bit),
    .i_en        (w_win),
    .i_init      (w_sof),
    .o_is_stuff  (w_is_stuff),
    .o_stuff_err (w_stuff_err),
    .o_will_pend (w_will_pend)
  );

  // Field FSM: advances on sample points, registers pulses, header fields and window control.
  always_ff @(posedge clock) begin
    if (reset) begin
      r_state       <= S_IDLE;
      r_cnt         <= '0;
      r_err_cnt     <= '0;
      r_crc_tail    <= 1'b0;
      r_f_stf       <= 1'b1;
      r_bit_valid   <= 1'b0;
      r_stuff_bit   <= 1'b0;
      r_stuff_error <= 1'b0;
      r_form_error  <= 1'b0;
      r_frame_done  <= 1'b0;
      r_id          <= '0;
      r_ide         <= 1'b0;
      r_rtr         <= 1'b0;
      r_dlc         <= '0;
      r_ack_ok      <= 1'b0;
    end else begin
      r_bit_valid   <= 1'b0;
      r_stuff_bit   <= 1'b0;
      r_stuff_error <= 1'b0;
      r_form_error  <= 1'b0;
      r_frame_done  <= 1'b0;
      if (w_sof) begin
        // Start of frame from IDLE or the last IFS bit: clear the header and open the window.
        r_state    <= S_ID_A;
        r_cnt      <= '0;
        r_crc_tail <= 1'b0;
        r_f_stf    <= 1'b0;
        r_id       <= '0;
        r_ide      <= 1'b0;
        r_rtr      <= 1'b0;
        r_dlc      <= '0;
        r_ack_ok   <= 1'b0;
      end else if (sp) begin
        if (w_win) begin
          if (w_stuff_err) begin
            r_stuff_error <= 1'b1;
            r_state       <= S_ERROR;
            r_f_stf       <= 1'b1;
            r_err_cnt     <= '0;
            r_crc_tail    <= 1'b0;
          end else if (w_is_stuff) begin
            r_stuff_bit <= 1'b1;
            if (r_crc_tail) begin
              r_state    <= S_CRC_DEL;
              r_f_stf    <= 1'b1;
              r_crc_tail <= 1'b0;
              r_cnt      <= '0;
            end
          end else begin
            r_bit_valid <= 1'b1;
            r_cnt       <= r_cnt + 6'd1;
            case (r_state)
              S_ID_A: begin
                r_id[28:18] <= {r_id[27:18], rx_bit};
                if (r_cnt == ID_A_LAST) begin
                  r_state <= S_RTR_A;
                  r_cnt   <= '0;
                end
              end
              S_RTR_A: begin
                // Holds SRR for extended frames until RTR_B overwrites it.
                r_rtr   <= rx_bit;
                r_state <= S_IDE;
                r_cnt   <= '0;
              end
              S_IDE: begin
                r_ide   <= rx_bit;
                r_state <= rx_bit ? S_ID_B : S_R0;
                r_cnt   <= '0;
              end
              S_ID_B: begin
                r_id[17:0] <= {r_id[16:0], rx_bit};
                if (r_cnt == ID_B_LAST) begin
                  r_state <= S_RTR_B;
                  r_cnt   <= '0;
                end
              end
              S_RTR_B: begin
                r_rtr   <= rx_bit;
                r_state <= S_R1;
                r_cnt   <= '0;
              end
              S_R1: begin
                r_state <= S_R0;
                r_cnt   <= '0;
              end
              S_R0: begin
                r_state <= S_DLC;
                r_cnt   <= '0;
              end
              S_DLC: begin
                r_dlc <= w_dlc_shift;
                if (r_cnt == DLC_LAST) begin
                  r_state <= (r_rtr || (w_dlc_bits == 7'd0)) ? S_CRC : S_DATA;
                  r_cnt   <= '0;
                end
              end
              S_DATA: begin
                if ({1'b0, r_cnt} == (w_data_bits - 7'd1)) begin
                  r_state <= S_CRC;
                  r_cnt   <= '0;
                end
              end
              S_CRC: begin
                if (r_cnt == CRC_LAST) begin
                  r_cnt <= r_cnt;
                  if (w_will_pend) begin
                    // Last CRC bit closed a run: wait for its stuff bit before the delimiter.
                    r_crc_tail <= 1'b1;
                  end else begin
                    r_state <= S_CRC_DEL;
                    r_f_stf <= 1'b1;
                    r_cnt   <= '0;
                  end
                end
              end
              default: ;
            endcase
          end
        end else begin
          case (r_state)
            S_CRC_DEL, S_ACK_DEL: begin
              if (rx_bit) begin
                r_bit_valid <= 1'b1;
                r_state     <= (r_state == S_CRC_DEL) ? S_ACK_SLOT : S_EOF;
                r_cnt       <= '0;
              end else begin
                r_form_error <= 1'b1;
                r_state      <= S_ERROR;
                r_err_cnt    <= '0;
              end
            end
            S_ACK_SLOT: begin
              r_bit_valid <= 1'b1;
              r_ack_ok    <= ~rx_bit;
              r_state     <= S_ACK_DEL;
              r_cnt       <= '0;
            end
            S_EOF: begin
              if (rx_bit) begin
                r_bit_valid <= 1'b1;
                if (r_cnt == EOF_LAST) begin
                  r_frame_done <= 1'b1;
                  r_state      <= S_IFS;
                  r_cnt        <= '0;
                end else begin
                  r_cnt <= r_cnt + 6'd1;
                end
              end else begin
                r_form_error <= 1'b1;
                r_state      <= S_ERROR;
                r_err_cnt    <= '0;
              end
            end
            S_IFS: begin
              // A dominant last IFS bit is handled as SOF above; earlier ones are form errors.
              if (rx_bit) begin
                r_bit_valid <= 1'b1;
                if (r_cnt == IFS_LAST) begin
                  r_state <= S_IDLE;
                  r_cnt   <= '0;
                end else begin
                  r_cnt <= r_cnt + 6'd1;
                end
              end else begin
                r_form_error <= 1'b1;
                r_state      <= S_ERROR;
                r_err_cnt    <= '0;
              end
            end
            S_ERROR: begin
              if (!rx_bit) begin
                r_err_cnt <= '0;
              end else if (r_err_cnt == EW'(IDLE_BITS - 1)) begin
                r_state   <= S_IDLE;
                r_err_cnt <= '0;
              end else begin
                r_err_cnt <= r_err_cnt + EW'(1);
              end
            end
            S_IDLE: ;
            default: begin
              r_state <= S_IDLE;
              r_f_stf <= 1'b1;
            end
          endcase
        end
      end
    end
  end

  assign f_stf       = r_f_stf;
  assign bit_valid   = r_bit_valid;
  assign stuff_bit   = r_stuff_bit;
  assign stuff_error = r_stuff_error;
  assign form_error  = r_form_error;
  assign frame_done  = r_frame_done;
  assign state       = r_state;
  assign id          = r_id;
  assign ide         = r_ide;
  assign rtr         = r_rtr;
  assign dlc         = r_dlc;
  assign ack_ok      = r_ack_ok;

endmodule

// File: tb/tb_can_frame_sequencer.sv
// Directed bench for can_frame_sequencer: frame table plus hand-written corner sequences.
module tb_can_frame_sequencer;
  import can_pkg::*;

  logic        clock = 1'b0;
  logic        reset, sp, rx_bit;
  logic        f_stf, bit_valid, stuff_bit, stuff_error, form_error, frame_done;
  logic [4:0]  state;
  logic [28:0] id;
  logic        ide, rtr, ack_ok;
  logic [3:0]  dlc;

  can_frame_sequencer dut (
    .clock(clock), .reset(reset), .sp(sp), .rx_bit(rx_bit),
    .f_stf(f_stf), .bit_valid(bit_valid), .stuff_bit(stuff_bit),
    .stuff_error(stuff_error), .form_error(form_error), .frame_done(frame_done),
    .state(state), .id(id), .ide(ide), .rtr(rtr), .dlc(dlc), .ack_ok(ack_ok)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        ide;
    logic [28:0] id;
    logic        rtr;
    logic [3:0]  dlc;
    logic [63:0] data;
    logic [14:0] crc;
    int          exp_valid;
    logic        exp_data;
  } vec_t;

  vec_t vecs[5];
  int   n_checks = 0;
  int   n_pass   = 0;
  int   c_bv, c_sb, c_se, c_fe, c_fd, c_data;
  logic p_bv, p_sb, p_se, p_fe, p_fd;
  logic win_q[$];
  logic stf_q[$];
  int   first_hi;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  task automatic do_reset();
    @(negedge clock);
    reset = 1'b1; sp = 1'b0; rx_bit = 1'b1;
    @(negedge clock);
    @(negedge clock);
    reset = 1'b0;
  endtask

  task automatic clear_counts();
    c_bv = 0; c_sb = 0; c_se = 0; c_fe = 0; c_fd = 0; c_data = 0;
  endtask

  // One sample point: sp high for one clock, then low for one; outputs sampled mid-way.
  task automatic send_bit(input logic b);
    @(negedge clock);
    rx_bit = b; sp = 1'b1;
    @(negedge clock);
    sp = 1'b0;
    p_bv = bit_valid; p_sb = stuff_bit; p_se = stuff_error; p_fe = form_error; p_fd = frame_done;
    c_bv += int'(bit_valid); c_sb += int'(stuff_bit); c_se += int'(stuff_error);
    c_fe += int'(form_error); c_fd += int'(frame_done);
    if (state == S_DATA) c_data++;
  endtask

  task automatic push_bits(input logic [63:0] val, input int n);
    for (int i = n - 1; i >= 0; i--) win_q.push_back(val[i]);
  endtask

  // Unstuffed SOF..CRC bit stream, then a standard stuffing encoder over it.
  task automatic build_frame(input vec_t v);
    int   nb, run;
    logic last;
    win_q.delete();
    stf_q.delete();
    win_q.push_back(1'b0);
    push_bits(64'(v.id[28:18]), 11);
    if (v.ide) begin
      win_q.push_back(1'b1);
      win_q.push_back(1'b1);
      push_bits(64'(v.id[17:0]), 18);
      win_q.push_back(v.rtr);
      win_q.push_back(1'b0);
      win_q.push_back(1'b0);
    end else begin
      win_q.push_back(v.rtr);
      win_q.push_back(1'b0);
      win_q.push_back(1'b0);
    end
    push_bits(64'(v.dlc), 4);
    nb = (v.dlc > 4'd8) ? 8 : int'(v.dlc);
    if (!v.rtr) for (int i = 0; i < nb * 8; i++) win_q.push_back(v.data[63 - i]);
    push_bits(64'(v.crc), 15);
    last = 1'b1; run = 0;
    foreach (win_q[i]) begin
      stf_q.push_back(win_q[i]);
      if (win_q[i] == last) run++;
      else begin run = 1; last = win_q[i]; end
      if (run == 5) begin
        stf_q.push_back(~last);
        last = ~last;
        run = 1;
      end
    end
  endtask

  task automatic run_frame(input vec_t v, input logic [2:0] ifs);
    build_frame(v);
    clear_counts();
    first_hi = -1;
    foreach (stf_q[i]) begin
      send_bit(stf_q[i]);
      if (first_hi < 0 && f_stf) first_hi = i;
    end
    send_bit(1'b1);
    send_bit(1'b0);
    send_bit(1'b1);
    for (int i = 0; i < 7; i++) send_bit(1'b1);
    send_bit(ifs[2]);
    send_bit(ifs[1]);
    send_bit(ifs[0]);
  endtask

  initial begin
    vec_t vc;
    logic found;
    int   k;
    reset = 1'b0; sp = 1'b0; rx_bit = 1'b1;
    //                ide   id             rtr   dlc    data                  crc              valid  data?
    vecs[0] = '{1'b0, 29'h048C0000, 1'b0, 4'd1,  64'h5500000000000000, 15'h2A5B,        54,  1'b1};
    vecs[1] = '{1'b1, 29'h1ABCDEF0, 1'b1, 4'd8,  64'h0,                15'h1357,        66,  1'b0};
    vecs[2] = '{1'b0, 29'h1FFC0000, 1'b0, 4'd2,  64'hFF00000000000000, 15'h0000,        62,  1'b1};
    vecs[3] = '{1'b0, 29'h02AC0000, 1'b0, 4'd12, 64'h0123456789ABCDEF, 15'h4C2D,       110,  1'b1};
    vecs[4] = '{1'b0, 29'h00000000, 1'b1, 4'd3,  64'h0,                15'h7FFF,        46,  1'b0};

    do_reset();
    @(negedge clock);
    check("reset_state", 64'(state), 64'(S_IDLE));
    check("reset_f_stf", 64'(f_stf), 64'd1);
    check("reset_pulses", 64'({bit_valid, stuff_bit, stuff_error, form_error, frame_done}), 64'd0);
    check("reset_hdr", 64'({id, ide, rtr, dlc, ack_ok}), 64'd0);

    // Table-driven full frames.
    for (int t = 0; t < 5; t++) begin
      run_frame(vecs[t], 3'b111);
      $display("frame %0d: id=%0h ide=%0b rtr=%0b dlc=%0d valid=%0d stuff=%0d done=%0d",
               t, id, ide, rtr, dlc, c_bv, c_sb, c_fd);
      check($sformatf("v%0d_valid", t), 64'(c_bv), 64'(vecs[t].exp_valid));
      check($sformatf("v%0d_stuff", t), 64'(c_sb), 64'(stf_q.size() - win_q.size()));
      check($sformatf("v%0d_errs", t), 64'(c_se + c_fe), 64'd0);
      check($sformatf("v%0d_done", t), 64'(c_fd), 64'd1);
      check($sformatf("v%0d_fstf_rise", t), 64'(first_hi), 64'(stf_q.size() - 1));
      check($sformatf("v%0d_id", t), 64'(id), 64'(vecs[t].id));
      check($sformatf("v%0d_ide", t), 64'(ide), 64'(vecs[t].ide));
      check($sformatf("v%0d_rtr", t), 64'(rtr), 64'(vecs[t].rtr));
      check($sformatf("v%0d_dlc", t), 64'(dlc), 64'(vecs[t].dlc));
      check($sformatf("v%0d_ack", t), 64'(ack_ok), 64'd1);
      check($sformatf("v%0d_data_seen", t), 64'(c_data > 0), 64'(vecs[t].exp_data));
      check($sformatf("v%0d_idle", t), 64'(state), 64'(S_IDLE));
    end

    // Stuff bit inside ID_A does not advance the ID counter.
    do_reset();
    clear_counts();
    for (int i = 0; i < 5; i++) send_bit(1'b0);
    send_bit(1'b1);
    $display("stuff in id: sb=%0b bv=%0b state=%0d", p_sb, p_bv, state);
    check("idstuff_pulse", 64'({p_sb, p_bv}), 64'b10);
    check("idstuff_state", 64'(state), 64'(S_ID_A));
    send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0); send_bit(1'b1); send_bit(1'b0);
    check("idstuff_10bits", 64'(state), 64'(S_ID_A));
    send_bit(1'b1);
    check("idstuff_11bits", 64'(state), 64'(S_RTR_A));
    check("idstuff_count", 64'(c_sb), 64'd1);

    // Sixth equal bit is a stuff error; recovery needs 11 consecutive recessive samples.
    do_reset();
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    $display("stuff error: se=%0b state=%0d f_stf=%0b", p_se, state, f_stf);
    check("stferr_pulse", 64'(p_se), 64'd1);
    check("stferr_state", 64'({state, f_stf}), 64'({S_ERROR, 1'b1}));
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("err_10rec", 64'(state), 64'(S_ERROR));
    send_bit(1'b1);
    check("err_11rec", 64'(state), 64'(S_IDLE));
    for (int i = 0; i < 6; i++) send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    send_bit(1'b0);
    for (int i = 0; i < 10; i++) send_bit(1'b1);
    check("err_restart", 64'(state), 64'(S_ERROR));
    send_bit(1'b1);
    check("err_restart_exit", 64'(state), 64'(S_IDLE));

    // CRC ending in five recessive bits: trailing stuff bit then a bad CRC delimiter.
    do_reset();
    vc = vecs[0];
    vc.crc = 15'b101010101011111;
    build_frame(vc);
    clear_counts();
    for (int i = 0; i < stf_q.size() - 1; i++) send_bit(stf_q[i]);
    check("crctail_fstf_low", 64'({f_stf, state}), 64'({1'b0, S_CRC}));
    send_bit(stf_q[stf_q.size() - 1]);
    $display("crc tail stuff: bit=%0b sb=%0b f_stf=%0b state=%0d", stf_q[stf_q.size() - 1], p_sb, f_stf, state);
    check("crctail_stuff", 64'({p_sb, p_bv}), 64'b10);
    check("crctail_fstf_high", 64'({f_stf, state}), 64'({1'b1, S_CRC_DEL}));
    send_bit(1'b0);
    check("crcdel_form", 64'({p_fe, state}), 64'({1'b1, S_ERROR}));

    // Reset coincident with a sample point in DATA, then a clean frame.
    do_reset();
    build_frame(vecs[0]);
    found = 1'b0;
    k = 0;
    while (!found && k < stf_q.size()) begin
      send_bit(stf_q[k]);
      if (state == S_DATA) found = 1'b1;
      k++;
    end
    check("rst_reached_data", 64'(found), 64'd1);
    send_bit(stf_q[k]);
    @(negedge clock);
    reset = 1'b1; sp = 1'b1; rx_bit = 1'b0;
    @(negedge clock);
    sp = 1'b0;
    $display("reset mid-data: state=%0d f_stf=%0b id=%0h", state, f_stf, id);
    check("rst_state", 64'({state, f_stf}), 64'({S_IDLE, 1'b1}));
    check("rst_pulses", 64'({bit_valid, stuff_bit, stuff_error, form_error, frame_done}), 64'd0);
    check("rst_hdr", 64'({id, dlc}), 64'd0);
    reset = 1'b0;
    run_frame(vecs[0], 3'b111);
    $display("after reset frame: id=%0h valid=%0d done=%0d", id, c_bv, c_fd);
    check("rst_refr_id", 64'(id), 64'(29'h048C0000));
    check("rst_refr_valid", 64'(c_bv), 64'd54);
    check("rst_refr_done", 64'(c_fd), 64'd1);

    // Dominant third IFS bit starts a new frame.
    do_reset();
    run_frame(vecs[4], 3'b110);
    $display("ifs3 sof: state=%0d f_stf=%0b done=%0d", state, f_stf, c_fd);
    check("ifs3_sof", 64'({state, f_stf}), 64'({S_ID_A, 1'b0}));
    check("ifs3_done", 64'(c_fd), 64'd1);

    // Dominant first IFS bit is a form error.
    do_reset();
    run_frame(vecs[4], 3'b011);
    $display("ifs1 dominant: fe=%0d state=%0d", c_fe, state);
    check("ifs1_form", 64'(c_fe), 64'd1);
    check("ifs1_state", 64'(state), 64'(S_ERROR));

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/can_frame_sequencer.md
Name: can_frame_sequencer

Overview:
- Tracks CAN 2.0A/B frame fields bit by bit from sampled bus values, strobed by the sample-point pulse.
- Generates the stuffing-window control f_stf that drives the destuffing block: stuffing is active from SOF through the CRC sequence and disabled from the CRC delimiter onward.
- Classifies each sampled bit as a data bit or a stuff bit, flags stuff and form errors, and latches the decoded header fields.
- Sits between the bit-timing logic and the frame decoder/CRC checker.

Parameters:
- STUFF_LEN, 5, count of equal consecutive bits after which a stuff bit is expected.
- MAX_DATA_BYTES, 8, cap on data length; DLC values 9-15 are treated as this value.
- IDLE_BITS, 11, consecutive recessive bits required to leave ERROR.

Ports:
- clock  in  1  system clock.
- reset  in  1  synchronous, active-high reset.
- sp  in  1  single-cycle sample-point pulse; consecutive pulses are at least 2 clocks apart.
- rx_bit  in  1  sampled bus value, qualified by sp (0 = dominant).
- f_stf  out  1  1 = stuffing disabled (same polarity as the destuffing block's F_STF input).
- bit_valid  out  1  1-clock pulse: accepted non-stuff bit.
- stuff_bit  out  1  1-clock pulse: bit discarded as stuff.
- stuff_error  out  1  1-clock pulse.
- form_error  out  1  1-clock pulse.
- frame_done  out  1  1-clock pulse on the last EOF bit.
- state  out  5  current field state (package enum).
- id  out  29  identifier; base ID in [28:18], extension in [17:0].
- ide  out  1  latched IDE bit.
- rtr  out  1  latched RTR bit.
- dlc  out  4  latched DLC.
- ack_ok  out  1  latched 1 when the ACK slot is sampled dominant.

Behaviour:
- Reset (synchronous, wins over a coincident sp):
  - State goes to IDLE.
  - f_stf=1; all pulse outputs 0; id, ide, rtr, dlc and ack_ok go to 0; run counter cleared.
- All state changes occur on the clock edge where sp=1. Pulse outputs assert in the cycle after that edge, for exactly one clock.
- States and field lengths:
  - IDLE, SOF(1), ID_A(11), RTR_A(1), IDE(1), ID_B(18), RTR_B(1), R1(1), R0(1), DLC(4), DATA(8*n), CRC(15), CRC_DEL(1), ACK_SLOT(1), ACK_DEL(1), EOF(7), IFS(3), ERROR.
  - A bit counter counts valid bits inside each field.
- Transitions:
  - IDLE: rx_bit=0 goes to SOF processing (SOF consumed); the next state is ID_A. rx_bit=1 stays in IDLE.
  - Standard frame: RTR_A, then IDE. IDE=0 goes to R0, then DLC.
  - Extended frame: IDE=1 goes to ID_B, RTR_B, R1, R0, DLC. In this case the bit sampled in RTR_A is SRR, and rtr takes the RTR_B value.
  - Data length: n = min(dlc, MAX_DATA_BYTES). If rtr=1 or n=0, DLC goes straight to CRC.
  - CRC is followed by CRC_DEL, ACK_SLOT, ACK_DEL, EOF, IFS, then IDLE.
  - A dominant bit on IFS bit 3 is treated as SOF of the next frame. A dominant bit on IFS bit 1 or 2 raises form_error.
- Stuffing window and run tracking:
  - f_stf=0 from the SOF edge until the last CRC bit and any pending stuff bit after it are consumed; f_stf=1 otherwise.
  - The SOF bit initialises the run: last=0, run=1.
  - Inside the window, with no stuff pending: assert bit_valid. If rx_bit==last, run+1; otherwise run=1 and last=rx_bit. When run reaches STUFF_LEN, set stuff_pending.
  - Inside the window, with stuff_pending: if rx_bit!=last, assert stuff_bit, set run=1, last=rx_bit, clear pending, and do not advance the field. If rx_bit==last, assert stuff_error and go to ERROR.
  - If the last CRC bit completes a run of STUFF_LEN, the stuff bit is still expected. CRC_DEL is entered only after that bit, and f_stf rises then.
- Fixed-form checks:
  - CRC_DEL, ACK_DEL and all EOF bits must be 1; otherwise assert form_error and go to ERROR.
  - ACK_SLOT latches ack_ok = ~rx_bit. No error is raised on a missing ACK.
  - bit_valid is also asserted for accepted bits outside the window, excluding IDLE and ERROR.
- frame_done asserts with the 7th EOF bit.
- Header capture:
  - id, ide, rtr and dlc shift in MSB-first while the frame is in progress.
  - They are cleared on SOF and hold their values from frame_done until the next SOF.
- ERROR:
  - f_stf=1.
  - Count consecutive recessive samples. Any dominant sample restarts the count.
  - After IDLE_BITS recessive samples, go to IDLE.

Decomposition:
- can_pkg holds:
  - the state enum typedef;
  - field-length constants (ID_A_LEN=11, ID_B_LEN=18, DLC_LEN=4, CRC_LEN=15, EOF_LEN=7, IFS_LEN=3).
- Sub-module can_run_tracker: holds last bit, run counter and stuff_pending; takes a window enable. It returns the is_stuff and stuff_err classification to the sequencer FSM.

Test Plan:
- Standard frame, ID 0x123, DLC=1, data 0x55, correct stuffing -> 11+1+1+1+4+8+15 valid bits in the window; frame_done once; id[28:18]=0x123, dlc=1; f_stf rises on the clock after the last CRC bit.
- SOF followed by ID bits 0,0,0,0 (5 dominant including SOF), then stuff bit 1 -> stuff_bit pulse once; ID counter does not advance on the stuff bit.
- Same stimulus but a 6th dominant bit -> stuff_error pulse, state=ERROR; 11 recessive samples -> IDLE; 10 recessive, 1 dominant, then 10 recessive -> still ERROR.
- Extended frame, IDE=1, ID=0x1ABCDEF0, RTR_B=1, DLC=8 -> no DATA state; id=0x1ABCDEF0, rtr=1, ide=1.
- CRC whose last 5 bits are 1 -> stuff bit 0 accepted, then CRC_DEL; f_stf stays 0 until after the stuff bit. CRC_DEL sampled 0 -> form_error.
- reset asserted mid-DATA with sp in the same cycle -> state=IDLE, f_stf=1, no pulses; a new SOF decodes normally.
